// File: rtl/multicycle_sequencer_if.sv
// Shared memory-port handshake between the multi-cycle sequencer (master)
// and the memory subsystem (slave).
interface multicycle_sequencer_if;
   logic mem_req;
   logic mem_we;
   logic mem_addr_sel;
   logic mem_ready;

   modport master (
      output mem_req,
      output mem_we,
      output mem_addr_sel,
      input  mem_ready
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_addr_sel,
      output mem_ready
   );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle phase controller for the RV32I core: IDLE/FETCH/DECODE/EXECUTE/MEM/WB
// with a stalling memory handshake and timeout. Optional counters: SEQ_PERF_CNT_EN.
module multicycle_sequencer #(
   parameter int unsigned TIMEOUT_CYC = 32'd64,
   parameter int unsigned TO_W        = 32'd8
) (
   input  logic                          clock,
   input  logic                          reset_n,
   multicycle_sequencer_if.master        mem,
   input  logic [4:0]                    opcode,
   input  logic                          dec_reg_w_en,
   input  logic                          dec_mem_rw,
   output logic                          ir_w_en,
   output logic                          mdr_w_en,
   output logic                          pc_w_en,
   output logic                          reg_w_en,
   output logic [2:0]                    state,
   output logic                          halted,
   output logic [1:0]                    err,
   output logic [31:0]                   cycle_cnt,
   output logic [31:0]                   instret_cnt
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'b000,
      ST_FETCH  = 3'b001,
      ST_DECODE = 3'b010,
      ST_EXEC   = 3'b011,
      ST_MEM    = 3'b100,
      ST_WB     = 3'b101,
      ST_HALT   = 3'b110
   } state_t;

   localparam logic [4:0] OP_LUI    = 5'b01101;
   localparam logic [4:0] OP_AUIPC  = 5'b00101;
   localparam logic [4:0] OP_JAL    = 5'b11011;
   localparam logic [4:0] OP_JALR   = 5'b11001;
   localparam logic [4:0] OP_BRANCH = 5'b11000;
   localparam logic [4:0] OP_LOAD   = 5'b00000;
   localparam logic [4:0] OP_STORE  = 5'b01000;
   localparam logic [4:0] OP_OPIMM  = 5'b00100;
   localparam logic [4:0] OP_OP     = 5'b01100;
   localparam logic [4:0] OP_SYSTEM = 5'b11100;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_ILLEGAL = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;

   // The limit is hit on the stalled cycle whose pre-increment count is TIMEOUT_CYC-1,
   // so the request is held for exactly TIMEOUT_CYC stalled cycles.
   localparam bit              TO_EN   = (TIMEOUT_CYC != 32'd0);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 32'd1);

   function automatic logic is_legal_op(input logic [4:0] op);
      case (op)
         OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
         OP_LOAD, OP_STORE, OP_OPIMM, OP_OP, OP_SYSTEM: return 1'b1;
         default:                                        return 1'b0;
      endcase
   endfunction

   function automatic logic is_mem_op(input logic [4:0] op);
      return (op == OP_LOAD) || (op == OP_STORE);
   endfunction

   function automatic logic blocks_rd_write(input logic [4:0] op);
      return (op == OP_STORE) || (op == OP_BRANCH);
   endfunction

   state_t          state_r;
   state_t          state_nxt_s;
   logic [1:0]      err_r;
   logic [1:0]      err_nxt_s;
   logic [TO_W-1:0] to_cnt_r;
   logic [TO_W-1:0] to_cnt_nxt_s;
   logic            stall_s;
   logic            to_hit_s;
   logic            mem_req_r;
   logic            mem_addr_sel_r;
   logic            pc_w_en_r;
   logic            halted_r;
   logic            ir_w_en_s;
   logic            mdr_w_en_s;
   logic            reg_w_en_s;
   logic            mem_we_s;

   // Stall detection and timeout limit check; a ready on the limit cycle wins.
   always_comb begin
      stall_s  = mem_req_r & ~mem.mem_ready;
      to_hit_s = 1'b0;
      if (TO_EN && stall_s && (to_cnt_r == TO_LAST)) begin
         to_hit_s = 1'b1;
      end else begin
         to_hit_s = 1'b0;
      end
   end

   // Next-phase and halt-cause selection.
   always_comb begin
      state_nxt_s = state_r;
      err_nxt_s   = err_r;
      case (state_r)
         ST_IDLE: state_nxt_s = ST_FETCH;
         ST_FETCH: begin
            if (mem.mem_ready) begin
               state_nxt_s = ST_DECODE;
            end else if (to_hit_s) begin
               state_nxt_s = ST_HALT;
               err_nxt_s   = ERR_TIMEOUT;
            end else begin
               state_nxt_s = ST_FETCH;
            end
         end
         ST_DECODE: begin
            if (opcode == OP_SYSTEM) begin
               state_nxt_s = ST_HALT;
               err_nxt_s   = ERR_NONE;
            end else if (!is_legal_op(opcode)) begin
               state_nxt_s = ST_HALT;
               err_nxt_s   = ERR_ILLEGAL;
            end else begin
               state_nxt_s = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (is_mem_op(opcode)) begin
               state_nxt_s = ST_MEM;
            end else begin
               state_nxt_s = ST_WB;
            end
         end
         ST_MEM: begin
            if (mem.mem_ready) begin
               state_nxt_s = ST_WB;
            end else if (to_hit_s) begin
               state_nxt_s = ST_HALT;
               err_nxt_s   = ERR_TIMEOUT;
            end else begin
               state_nxt_s = ST_MEM;
            end
         end
         ST_WB:   state_nxt_s = ST_FETCH;
         ST_HALT: state_nxt_s = ST_HALT;
         default: state_nxt_s = ST_HALT;
      endcase
   end

   // Timeout counter advances only while a request keeps stalling.
   always_comb begin
      to_cnt_nxt_s = '0;
      if (stall_s && ((state_nxt_s == ST_FETCH) || (state_nxt_s == ST_MEM))) begin
         to_cnt_nxt_s = to_cnt_r + TO_W'(1);
      end else begin
         to_cnt_nxt_s = '0;
      end
   end

   // Phase register with registered, next-state-decoded port outputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r        <= ST_IDLE;
         err_r          <= ERR_NONE;
         to_cnt_r       <= '0;
         mem_req_r      <= 1'b0;
         mem_addr_sel_r <= 1'b0;
         pc_w_en_r      <= 1'b0;
         halted_r       <= 1'b0;
      end else begin
         state_r        <= state_nxt_s;
         err_r          <= err_nxt_s;
         to_cnt_r       <= to_cnt_nxt_s;
         mem_req_r      <= (state_nxt_s == ST_FETCH) || (state_nxt_s == ST_MEM);
         mem_addr_sel_r <= (state_nxt_s == ST_MEM);
         pc_w_en_r      <= (state_nxt_s == ST_WB);
         halted_r       <= (state_nxt_s == ST_HALT);
      end
   end

   // Handshake-qualified strobes; these must follow mem_ready in the same cycle.
   always_comb begin
      ir_w_en_s  = 1'b0;
      mdr_w_en_s = 1'b0;
      reg_w_en_s = 1'b0;
      mem_we_s   = 1'b0;
      case (state_r)
         ST_FETCH: ir_w_en_s = mem_req_r & mem.mem_ready;
         ST_MEM: begin
            mdr_w_en_s = mem_req_r & mem.mem_ready & ~dec_mem_rw;
            mem_we_s   = mem_req_r & dec_mem_rw;
         end
         ST_WB: begin
            if (blocks_rd_write(opcode)) begin
               reg_w_en_s = 1'b0;
            end else begin
               reg_w_en_s = dec_reg_w_en;
            end
         end
         default: begin
            ir_w_en_s  = 1'b0;
            mdr_w_en_s = 1'b0;
            reg_w_en_s = 1'b0;
            mem_we_s   = 1'b0;
         end
      endcase
   end

`ifdef SEQ_PERF_CNT_EN
   logic [31:0] cycle_cnt_r;
   logic [31:0] instret_cnt_r;

   // Active-cycle and retired-instruction counters, free-running with wrap.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cycle_cnt_r   <= 32'd0;
         instret_cnt_r <= 32'd0;
      end else begin
         if ((state_r != ST_IDLE) && (state_r != ST_HALT)) begin
            cycle_cnt_r <= cycle_cnt_r + 32'd1;
         end
         if (state_r == ST_WB) begin
            instret_cnt_r <= instret_cnt_r + 32'd1;
         end
      end
   end

   assign cycle_cnt   = cycle_cnt_r;
   assign instret_cnt = instret_cnt_r;
`else
   assign cycle_cnt   = 32'd0;
   assign instret_cnt = 32'd0;
`endif

   assign mem.mem_req      = mem_req_r;
   assign mem.mem_we       = mem_we_s;
   assign mem.mem_addr_sel = mem_addr_sel_r;
   assign ir_w_en          = ir_w_en_s;
   assign mdr_w_en         = mdr_w_en_s;
   assign pc_w_en          = pc_w_en_r;
   assign reg_w_en         = reg_w_en_s;
   assign state            = state_r;
   assign halted           = halted_r;
   assign err              = err_r;

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle phase controller for the RV32I core.
- Steps each instruction through IDLE/FETCH/DECODE/EXECUTE/MEM/WB, stalls on a single shared memory port with a req/ready handshake, and gates the write enables produced by the combinational decoder so architectural state updates only in WB.
- Halts on ECALL, on an illegal opcode, or on a memory timeout.

Parameters:
- TIMEOUT_CYC, 64: max cycles mem_req may stay high without mem_ready before an error halt; 0 disables the timeout.
- TO_W, 8: width of the timeout counter; must satisfy TIMEOUT_CYC < 2^TO_W.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- opcode  in  5  inst[6:2] from the instruction register (valid from DECODE onward).
- dec_reg_w_en  in  1  reg_w_en from the control decoder.
- dec_mem_rw  in  1  mem_rw from the control decoder (1 = store).
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request.
- mem_we  out  1  write strobe, qualified by mem_req.
- mem_addr_sel  out  1  0 = PC (fetch), 1 = ALU result (data).
- ir_w_en  out  1  load instruction register.
- mdr_w_en  out  1  load memory data register.
- pc_w_en  out  1  update PC.
- reg_w_en  out  1  gated register-file write.
- state  out  3  current phase code.
- halted  out  1  sequencer stopped.
- err  out  2  halt cause: 00 none/ECALL, 01 illegal opcode, 10 memory timeout.
- cycle_cnt  out  32  see Optional Feature.
- instret_cnt  out  32  see Optional Feature.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state = IDLE (000); halted = 0; err = 00; timeout counter = 0.
  - All other outputs are 0 while in reset.
- State codes: IDLE 000, FETCH 001, DECODE 010, EXECUTE 011, MEM 100, WB 101, HALT 110.
- IDLE -> FETCH unconditionally on the first edge after reset release.
- FETCH:
  - mem_req = 1, mem_addr_sel = 0, mem_we = 0.
  - ir_w_en = mem_ready (combinational).
  - Leaves to DECODE on mem_ready.
- DECODE, one cycle. Next state from opcode:
  - 11100 (ECALL) -> HALT, err = 00.
  - Opcode outside {01101, 00101, 11011, 11001, 11000, 00000, 01000, 00100, 01100, 11100} -> HALT, err = 01.
  - Otherwise -> EXECUTE.
- EXECUTE, one cycle. Next state:
  - Load (00000) or store (01000) -> MEM.
  - Everything else -> WB.
- MEM:
  - mem_req = 1, mem_addr_sel = 1, mem_we = dec_mem_rw.
  - mdr_w_en = mem_ready & ~dec_mem_rw.
  - Leaves to WB on mem_ready.
- WB, one cycle:
  - pc_w_en = 1.
  - reg_w_en = dec_reg_w_en, forced to 0 for stores and branches regardless of the decoder.
  - Next state: FETCH.
- HALT:
  - Terminal; halted = 1.
  - All strobes and mem_req are 0.
  - Exited only by reset.
- Handshake rules:
  - mem_req held high until mem_ready is sampled high; the address select is stable throughout.
  - mem_ready while mem_req = 0 is ignored.
  - Exactly one ir_w_en/mdr_w_en pulse per request.
- Timeout:
  - Counter increments each cycle mem_req = 1 && mem_ready = 0, and clears on mem_ready or when leaving FETCH/MEM.
  - When the counter reaches TIMEOUT_CYC (nonzero) -> HALT, err = 10, mem_req drops the next cycle.
  - A mem_ready arriving on the same cycle as the limit completes normally; ready wins.
- Latency with zero-wait memory:
  - ALU/branch/jump/U-type instruction: 4 cycles (FETCH..WB).
  - Load/store: 5 cycles.
  - Each wait cycle adds 1.
- All strobes (ir_w_en, mdr_w_en, pc_w_en, reg_w_en) are single-cycle and mutually exclusive except that none overlaps mem_we.
- Reset asserted mid-MEM: mem_req drops immediately (asynchronously); no partial write strobe is held.

Optional Feature:
- Macro: SEQ_PERF_CNT_EN.
- Defined:
  - cycle_cnt increments every cycle state != IDLE/HALT.
  - instret_cnt increments on each WB cycle.
  - Both are 32-bit, wrap from 0xFFFFFFFF to 0, and reset to 0.
- Undefined: both outputs are constant 0 and no counter flops are synthesized.

Test Plan:
- ADDI (opcode 00100), mem_ready held 1:
  - state sequence 000,001,010,011,101,001.
  - ir_w_en at cycle 1, pc_w_en and reg_w_en at cycle 4; instret_cnt = 1.
- LW (00000) with 3 fetch wait cycles and 2 data wait cycles:
  - mem_addr_sel 0 then 1; mdr_w_en pulses once on data ready.
  - WB reached 10 cycles after IDLE exit.
- SW (01000), dec_reg_w_en forced 1:
  - mem_we = 1 only during MEM; reg_w_en stays 0 at WB; mdr_w_en never asserts.
- Opcode 11111 -> HALT with err = 01, halted = 1; subsequent mem_ready pulses produce no strobes.
- TIMEOUT_CYC = 4 and mem_ready stuck 0 in FETCH:
  - HALT, err = 10 after 4 stalled cycles.
  - Repeat with ready on the 4th cycle -> proceeds to DECODE, no error.
- ECALL (11100) -> HALT, err = 00.
- Assert reset_n low mid-MEM -> all outputs 0 immediately; release -> IDLE then FETCH.
